// File: rtl/fetch_pc_unit_pkg.sv
// Shared constants for the fetch stage: reset PC, memory address widths,
// the BIOS select bit and base RV32I opcodes.
package fetch_pc_unit_pkg;

   localparam logic [31:0] RESET_PC     = 32'h4000_0000;
   localparam int unsigned IMEM_AW      = 14;
   localparam int unsigned BIOS_AW      = 12;
   localparam int unsigned BIOS_SEL_BIT = 30;

   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_ARI    = 7'b0010011;
   localparam logic [6:0] OPC_ARR    = 7'b0110011;
   localparam logic [6:0] OPC_CSR    = 7'b1110011;

   typedef enum logic [2:0] {
      PcReset,
      PcJalr,
      PcBranch,
      PcHold,
      PcSeq
   } pc_sel_e;

   function automatic logic is_bios(input logic [31:0] pc);
      return pc[BIOS_SEL_BIT];
   endfunction

endpackage

// File: rtl/fetch_pc_unit_next_mux.sv
// Combinational next-PC priority select: reset, JALR, branch, stall hold, sequential.
module fetch_pc_unit_next_mux
   import fetch_pc_unit_pkg::*;
#(
   parameter logic [31:0] ResetPc = RESET_PC
) (
   input  logic        rst_i,
   input  logic        stall_i,
   input  logic        jalr_i,
   input  logic [31:0] jalr_target_i,
   input  logic        br_taken_i,
   input  logic [31:0] br_target_i,
   input  logic [31:0] pc_i,
   output logic [31:0] next_pc_o
);

   pc_sel_e sel;

   always_comb begin
      sel = PcSeq;
      if (rst_i)           sel = PcReset;
      else if (jalr_i)     sel = PcJalr;
      else if (br_taken_i) sel = PcBranch;
      else if (stall_i)    sel = PcHold;
   end

   always_comb begin
      next_pc_o = pc_i + 32'd4;
      unique case (sel)
         PcReset:  next_pc_o = ResetPc;
         PcJalr:   next_pc_o = jalr_target_i & 32'hFFFF_FFFE;
         PcBranch: next_pc_o = br_target_i;
         PcHold:   next_pc_o = pc_i;
         PcSeq:    next_pc_o = pc_i + 32'd4;
         default:  next_pc_o = pc_i + 32'd4;
      endcase
   end

endmodule

// File: rtl/fetch_pc_unit.sv
// Fetch stage: owns the fetch PC, drives BIOS/IMEM read ports and presents
// an aligned {pc_d, instr_d, valid_d} bundle to decode, plus a fetch counter.
module fetch_pc_unit
   import fetch_pc_unit_pkg::*;
#(
   parameter logic [31:0] ResetPc = RESET_PC,
   parameter int unsigned ImemAw  = IMEM_AW,
   parameter int unsigned BiosAw  = BIOS_AW
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              stall,
   input  logic              jalr,
   input  logic [31:0]       jalr_target,
   input  logic              br_taken,
   input  logic [31:0]       br_target,
   output logic [BiosAw-1:0] bios_addr,
   output logic              bios_en,
   input  logic [31:0]       bios_dout,
   output logic [ImemAw-1:0] imem_addr,
   output logic              imem_en,
   input  logic [31:0]       imem_dout,
   output logic [31:0]       pc_d,
   output logic [31:0]       instr_d,
   output logic              valid_d,
   output logic [31:0]       fetch_cnt
);

   logic [31:0] next_pc;
   logic [31:0] pc_q;
   logic        sel_q;
   logic        valid_q;
   logic [31:0] cnt_q, cnt_d;

   fetch_pc_unit_next_mux #(
      .ResetPc(ResetPc)
   ) u_next_mux (
      .rst_i        (rst),
      .stall_i      (stall),
      .jalr_i       (jalr),
      .jalr_target_i(jalr_target),
      .br_taken_i   (br_taken),
      .br_target_i  (br_target),
      .pc_i         (pc_q),
      .next_pc_o    (next_pc)
   );

   // Memories are addressed with next_pc so their 1-cycle read lines up with pc_q.
   always_comb begin
      bios_addr = next_pc[BiosAw+1:2];
      imem_addr = next_pc[ImemAw+1:2];
      bios_en   = is_bios(next_pc) & ~stall;
      imem_en   = ~is_bios(next_pc) & ~stall;
   end

   always_comb begin
      cnt_d = cnt_q;
      if (rst)                    cnt_d = 32'd0;
      else if (valid_q && !stall) cnt_d = cnt_q + 32'd1;
   end

   always_ff @(posedge clk) begin
      pc_q    <= next_pc;
      sel_q   <= is_bios(next_pc);
      valid_q <= ~rst;
      cnt_q   <= cnt_d;
   end

   always_comb begin
      pc_d      = pc_q;
      valid_d   = valid_q;
      fetch_cnt = cnt_q;
      instr_d   = sel_q ? bios_dout : imem_dout;
   end

endmodule
